if_id_queue: RTL

Decoupling buffer between the instruction-fetch stage and the decode stage. Captures each fetched {pc4, instruction} pair into a small circular FIFO and presents the oldest entry to decode. It back-pressures fetch through `push_ready`, which is the source of the PC register freeze, and it is emptied in one cycle when a branch is taken. Empty cycles present a NOP bubble to decode.

---
 rtl/if_id_queue_pkg.sv | 20 ++
 rtl/if_id_queue_if.sv | 31 +++
 rtl/if_id_queue_mem.sv | 40 ++++
 rtl/if_id_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode decoupling queue.
// Each queue entry is stored as the concatenation {pc4, inst}.
package if_id_queue_pkg;

  localparam int DEPTH_DEFAULT  = 4;
  localparam int DATA_W_DEFAULT = 32;

  // An all-zero word decodes as a NOP bubble in the decode stage.
  localparam logic [31:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between fetch (push side), the queue, and decode (pop side).
// The master drives fetch/decode requests; the slave is the queue itself.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic                         flush;
  logic                         push_valid;
  logic [DATA_W-1:0]            push_pc;
  logic [DATA_W-1:0]            push_inst;
  logic                         push_ready;
  logic                         pop_valid;
  logic                         pop_ready;
  logic [DATA_W-1:0]            id_pc;
  logic [DATA_W-1:0]            id_inst;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output flush, push_valid, push_pc, push_inst, pop_ready,
    input  push_ready, pop_valid, id_pc, id_inst, count
  );

  modport slave (
    input  flush, push_valid, push_pc, push_inst, pop_ready,
    output push_ready, pop_valid, id_pc, id_inst, count
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// Register file for the queue: one write port, one asynchronous read port,
// every entry cleared by reset.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int WIDTH  = 2 * DATA_W_DEFAULT,
  localparam int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [DEPTH-1:0][WIDTH-1:0] entries;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
          entry_q <= wdata_i;
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  assign rdata_o = entries[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: buffers {pc4, inst} from fetch, presents the oldest to
// decode, back-pressures fetch when full, and empties in one edge on a taken branch.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic                push_ready;
  logic                pop_valid;
  logic                do_push;
  logic                do_pop;
  logic [2*DATA_W-1:0] head_entry;

  // Ready/valid derive only from registered occupancy, never from pop_ready.
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);

  assign do_push = bus.push_valid && push_ready && !bus.flush;
  assign do_pop  = pop_valid && bus.pop_ready && !bus.flush;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.push_pc, bus.push_inst}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      // Everything in flight is on the wrong path.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.count      = count_q;
  assign bus.id_pc      = pop_valid ? head_entry[2*DATA_W-1:DATA_W] : '0;
  assign bus.id_inst    = pop_valid ? head_entry[DATA_W-1:0] : DATA_W'(NOP_INST);

endmodule
